// File: rtl/sample_window_buffer.sv
// sample_window_buffer: packs RS232 bytes into 16-bit samples and publishes
// a sliding WINDOW_LEN-sample window every HOP samples under a valid/ack handshake.
module sample_window_buffer #(
    parameter int WINDOW_LEN = 40,
    parameter int HOP        = 8
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_win_valid,
    input  logic        i_win_ack,
    input  logic [5:0]  i_rd_idx,
    output logic [15:0] o_rd_data,
    output logic        o_overrun,
    output logic [15:0] o_win_count
);
    localparam int DEPTH = WINDOW_LEN + HOP;

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t      state, state_n;
    logic        phase, phase_n;
    logic [7:0]  hi_byte, hi_n;
    logic [5:0]  wr_ptr, wr_ptr_n, base, base_n, fill, fill_n, new_cnt, new_cnt_n;
    logic        win_valid_n, overrun_n;
    logic [15:0] rd_data_n, count_n;
    logic [15:0] mem [DEPTH];
    logic        complete, drop, accept, issue;
    logic [6:0]  wr_inc, base_hop, rd_sum;
    logic [5:0]  rd_addr;

    assign complete = i_byte_valid && phase;
    // A full window plus HOP pending samples leaves no free slot outside the window
    assign drop     = complete && state == S_RUN && o_win_valid && new_cnt == 6'(HOP);
    assign accept   = complete && !drop;
    assign issue    = state == S_RUN && !o_win_valid && new_cnt >= 6'(HOP);
    assign wr_inc   = {1'b0, wr_ptr} + 7'd1;
    assign base_hop = {1'b0, base} + 7'(HOP);
    assign rd_sum   = {1'b0, base} + {1'b0, i_rd_idx};
    assign rd_addr  = rd_sum >= 7'(DEPTH) ? 6'(rd_sum - 7'(DEPTH)) : rd_sum[5:0];

    always_comb begin
        state_n     = state;
        win_valid_n = o_win_valid;
        base_n      = base;
        fill_n      = fill;
        new_cnt_n   = new_cnt;
        count_n     = o_win_count;
        phase_n     = i_byte_valid ? !phase : phase;
        hi_n        = (i_byte_valid && !phase) ? i_byte : hi_byte;
        wr_ptr_n    = !accept ? wr_ptr : (wr_inc >= 7'(DEPTH) ? 6'd0 : wr_inc[5:0]);
        overrun_n   = drop;
        rd_data_n   = i_rd_idx < 6'(WINDOW_LEN) ? mem[rd_addr] : 16'd0;
        if (state == S_FILL) begin
            fill_n = fill + {5'd0, accept};
            if (accept && fill == 6'(WINDOW_LEN - 1)) begin
                state_n     = S_RUN;
                win_valid_n = 1'b1;
                base_n      = 6'd0;
                new_cnt_n   = 6'd0;
                count_n     = o_win_count + 16'd1;
            end
        end else begin
            new_cnt_n   = new_cnt + {5'd0, accept} - (issue ? 6'(HOP) : 6'd0);
            win_valid_n = issue || (o_win_valid && !i_win_ack);
            base_n      = !issue ? base
                        : (base_hop >= 7'(DEPTH) ? 6'(base_hop - 7'(DEPTH)) : base_hop[5:0]);
            count_n     = o_win_count + {15'd0, issue};
        end
        if (i_clear) begin
            state_n     = S_FILL;
            win_valid_n = 1'b0;
            base_n      = 6'd0;
            fill_n      = 6'd0;
            new_cnt_n   = 6'd0;
            count_n     = 16'd0;
            phase_n     = 1'b0;
            hi_n        = hi_byte;
            wr_ptr_n    = 6'd0;
            overrun_n   = 1'b0;
            rd_data_n   = 16'd0;
        end
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state       <= S_FILL;
            o_win_valid <= 1'b0;
            base        <= 6'd0;
            fill        <= 6'd0;
            new_cnt     <= 6'd0;
            o_win_count <= 16'd0;
            phase       <= 1'b0;
            hi_byte     <= 8'd0;
            wr_ptr      <= 6'd0;
            o_overrun   <= 1'b0;
            o_rd_data   <= 16'd0;
        end else begin
            state       <= state_n;
            o_win_valid <= win_valid_n;
            base        <= base_n;
            fill        <= fill_n;
            new_cnt     <= new_cnt_n;
            o_win_count <= count_n;
            phase       <= phase_n;
            hi_byte     <= hi_n;
            wr_ptr      <= wr_ptr_n;
            o_overrun   <= overrun_n;
            o_rd_data   <= rd_data_n;
        end
    end

    always_ff @(posedge avm_clk) begin
        if (accept && !i_clear)
            mem[wr_ptr] <= {hi_byte, i_byte};
    end
endmodule
